// File: rtl/credit_pkg.sv
// Shared constants for both ends of the credit link.
// The sender's initial credit count must equal the receiver's buffer depth.
package credit_pkg;

    localparam int unsigned CREDIT_DEFAULT_DEPTH = 4;

    // Bits needed to hold an occupancy value from 0 up to n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/credit_queue_dpath.sv
// Storage and head/tail pointers for the credit receive queue.
// Pointers wrap explicitly, so depths that are not a power of two work.
module credit_queue_dpath #(
    parameter int unsigned p_msg_nbits   = 32,
    parameter int unsigned p_num_entries = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_enq,
    input  logic                   i_deq,
    input  logic [p_msg_nbits-1:0] i_enq_msg,
    output logic [p_msg_nbits-1:0] o_head_msg
);

    localparam int unsigned p_ptr_nbits = $clog2(p_num_entries);
    localparam logic [p_ptr_nbits-1:0] LAST_IDX = p_ptr_nbits'(p_num_entries - 1);

    logic [p_msg_nbits-1:0] r_mem [p_num_entries];
    logic [p_ptr_nbits-1:0] r_head;
    logic [p_ptr_nbits-1:0] r_tail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (i_enq)
                r_tail <= (r_tail == LAST_IDX) ? '0 : r_tail + p_ptr_nbits'(1);
            if (i_deq)
                r_head <= (r_head == LAST_IDX) ? '0 : r_head + p_ptr_nbits'(1);
        end
    end

    // Storage is deliberately not reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (i_enq)
            r_mem[r_tail] <= i_enq_msg;
    end

    assign o_head_msg = r_mem[r_head];

endmodule

// File: rtl/credit_recv_queue.sv
// Receiver end of a credit-based link: buffers incoming messages without
// backpressure, drains to a val/rdy consumer and returns one credit per dequeue.
module credit_recv_queue
    import credit_pkg::*;
#(
    parameter int unsigned p_msg_nbits   = 32,
    parameter int unsigned p_num_entries = CREDIT_DEFAULT_DEPTH,
    parameter int unsigned p_cnt_nbits   = cnt_width(p_num_entries)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   recv_val,
    input  logic [p_msg_nbits-1:0] recv_msg,
    output logic                   send_val,
    input  logic                   send_rdy,
    output logic [p_msg_nbits-1:0] send_msg,
    output logic                   credit_ret,
    output logic [p_cnt_nbits-1:0] num_used,
    output logic                   overflow_err
);

    logic [p_cnt_nbits-1:0] r_count;
    logic                   r_credit;
    logic                   r_ovf;

    logic w_full;
    logic w_enq;
    logic w_deq;
    logic w_drop;

    assign w_full = (r_count == p_cnt_nbits'(p_num_entries));
    assign w_deq  = send_val && send_rdy;
    // A full queue still accepts when the head leaves in the same cycle.
    assign w_enq  = recv_val && (!w_full || w_deq);
    assign w_drop = recv_val && w_full && !w_deq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_credit <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + p_cnt_nbits'(1);
                2'b01:   r_count <= r_count - p_cnt_nbits'(1);
                default: r_count <= r_count;
            endcase
            r_credit <= w_deq;
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

    credit_queue_dpath #(
        .p_msg_nbits   (p_msg_nbits),
        .p_num_entries (p_num_entries)
    ) u_dpath (
        .clk        (clk),
        .reset      (reset),
        .i_enq      (w_enq),
        .i_deq      (w_deq),
        .i_enq_msg  (recv_msg),
        .o_head_msg (send_msg)
    );

    assign send_val     = (r_count != '0);
    assign num_used     = r_count;
    assign credit_ret   = r_credit;
    assign overflow_err = r_ovf;

endmodule

// File: doc/credit_recv_queue.md
# credit_recv_queue

Receiver-side end of the credit-based flow-control link whose sender tracks available slots with an up/down credit counter (decrement on send, increment on credit return). Accepts messages without backpressure, buffers them in a FIFO, drains them to a val/rdy consumer, and returns exactly one credit per dequeued entry. Sits between the credit-link wire interface and a standard val/rdy consumer.

## Interface
- p_msg_nbits, 32, message width in bits
- p_num_entries, 4, buffer depth; equals the sender's initial credit count; must be ≥ 2
- p_cnt_nbits, $clog2(p_num_entries+1), width of occupancy outputs (derived; not overridden)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- recv_val  input  1  message present this cycle; the sender asserts it only while holding a credit
- recv_msg  input  p_msg_nbits  incoming message
- send_val  output  1  head entry valid
- send_rdy  input  1  consumer ready
- send_msg  output  p_msg_nbits  head entry payload
- credit_ret  output  1  one-cycle pulse; each pulse returns one credit
- num_used  output  p_cnt_nbits  current occupancy
- overflow_err  output  1  sticky; set on a dropped message

## Operation
- Enqueue: when recv_val=1 and the buffer is not full, or it is full and a dequeue occurs in the same cycle, write recv_msg at the tail and advance the tail pointer.
- Dequeue: when send_val && send_rdy, advance the head pointer.
- There is no bypass. A message is never visible on send_msg in the cycle it arrives.
- Occupancy update:
  - enqueue only: +1
  - dequeue only: −1
  - enqueue and dequeue together: unchanged
- Pointers wrap from p_num_entries−1 to 0. Non-power-of-two depths must work.
- Credit return: credit_ret is registered. It asserts in cycle t+1 for each dequeue in cycle t, so back-to-back dequeues give back-to-back pulses.
- Overflow: recv_val while full with no simultaneous dequeue is a protocol violation.
  - The message is dropped.
  - Occupancy and pointers are unchanged.
  - overflow_err is set and held until reset.
  - No credit is issued for the dropped message.
- send_val = (num_used != 0). send_msg is always the head entry; its value is don't-care when send_val=0.
- Invariant: credits returned since reset ≤ messages accepted since reset.

## Timing
- Reset values: send_val=0, credit_ret=0, num_used=0, overflow_err=0, head=tail=0. Storage contents are not reset.
- Reset asserted mid-operation flushes all entries at once. No credits are issued for flushed entries, because the sender's counter is also reset to p_num_entries.
- Enqueue-to-send_val latency is 1 cycle.
- Dequeue-to-credit_ret latency is 1 cycle.
- Round trip (enqueue → earliest credit_ret) is 2 cycles when the consumer is always ready.
- Sustained throughput is 1 message/cycle at any depth ≥ 2 with send_rdy held high.
- Full is combinational on registered occupancy: full = (num_used == p_num_entries).

## Structure
- A package credit_pkg holds:
  - a helper function for the count width
  - a localparam for the default depth, shared with the sender's credit counter so the two ends agree on the initial credit value
- One sub-module, credit_queue_dpath, holds:
  - the storage array
  - the head and tail pointer registers with wrap logic
- The top level holds:
  - the occupancy counter
  - the enqueue and dequeue control
  - the credit_ret register
  - the overflow flag
- No FSM beyond the occupancy counter. State is the pointers, the count, and two flag flops.

## Test plan
- Fill, then drain: depth 4, send_rdy=0.
  - Stimulus: enqueue 0xA0..0xA3 on consecutive cycles, then raise send_rdy.
  - Required: num_used reaches 4; send_msg shows 0xA0,0xA1,0xA2,0xA3 in order; credit_ret pulses in 4 consecutive cycles, each 1 cycle after its dequeue.
- Streaming: send_rdy=1, recv_val=1 for 20 cycles with msg = cycle index.
  - Required: send_val first high at cycle 1; output stream is 0..19 in order; num_used stays ≤ 1; 20 credit pulses.
- Full with simultaneous enqueue and dequeue: queue holds 4 entries, recv_val=1 with msg 0xBB, send_rdy=1.
  - Required: accepted; num_used stays 4; overflow_err stays 0; 0xBB dequeued fifth.
- Overflow: queue full, send_rdy=0, recv_val=1 with msg 0xEE.
  - Required: overflow_err=1 from the next cycle and sticky; 0xEE never appears; num_used stays 4; no credit pulse.
- Async reset mid-stream: assert reset between clock edges with 3 entries queued.
  - Required: send_val, num_used, credit_ret and overflow_err go to 0 before the next edge; after release, a single enqueue of 0x55 emerges one cycle later.
- Pointer wrap at depth 3 (non-power-of-two): run 10 random-gap enqueue/dequeue rounds.
  - Required: FIFO order is preserved; total credit pulses equal total dequeues.
